// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port front end for the 32-word data memory.
// Ports: p0 (core LSU) / p1 (debug/DMA) request + response, mem_* to the memory, busy.
module dmem_arbiter #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        p0_valid,
    output logic        p0_ready,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_rsp_valid,
    output logic [31:0] p0_rsp_rdata,
    output logic        p0_rsp_err,
    input  logic        p1_valid,
    output logic        p1_ready,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_rsp_valid,
    output logic [31:0] p1_rsp_rdata,
    output logic        p1_rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wen,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state_q, state_d;
    logic          last_grant_q;
    logic          owner_q;
    logic          we_q;
    logic          err_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rsp_rdata_q;
    logic          rsp_err_q;

    logic          win0, win1, open;
    logic          acc0, acc1, accept;
    logic [31:0]   sel_addr, sel_wdata;
    logic          sel_we, sel_err;

    // On a tie the port that did not win last time gets the grant.
    assign win0 = p0_valid & (~p1_valid | last_grant_q);
    assign win1 = p1_valid & (~p0_valid | ~last_grant_q);
    assign open = ((state_q == IDLE) | (state_q == RESP)) & ~Rst;

    assign p0_ready = open & win0;
    assign p1_ready = open & win1;
    assign acc0     = p0_valid & p0_ready;
    assign acc1     = p1_valid & p1_ready;
    assign accept   = acc0 | acc1;

    assign sel_addr  = acc1 ? p1_addr  : p0_addr;
    assign sel_wdata = acc1 ? p1_wdata : p0_wdata;
    assign sel_we    = acc1 ? p1_we    : p0_we;
    // Word index beyond DEPTH covers every nonzero upper address bit.
    assign sel_err   = (sel_addr[1:0] != 2'b00) |
                       (sel_addr[31:2] >= 30'(DEPTH));

    // Captured index/data drive the memory and hold outside ACCESS.
    assign mem_addr  = {{(32-AW){1'b0}}, idx_q};
    assign mem_wdata = wdata_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = accept ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy         = 1'b0;
        mem_wen      = 1'b0;
        p0_rsp_valid = 1'b0;
        p0_rsp_rdata = '0;
        p0_rsp_err   = 1'b0;
        p1_rsp_valid = 1'b0;
        p1_rsp_rdata = '0;
        p1_rsp_err   = 1'b0;
        unique case (state_q)
            ACCESS: begin
                busy    = 1'b1;
                // Reset in ACCESS must not let the write commit.
                mem_wen = we_q & ~err_q & ~Rst;
            end
            RESP: begin
                if (!Rst) begin
                    if (owner_q) begin
                        p1_rsp_valid = 1'b1;
                        p1_rsp_rdata = rsp_rdata_q;
                        p1_rsp_err   = rsp_err_q;
                    end else begin
                        p0_rsp_valid = 1'b1;
                        p0_rsp_rdata = rsp_rdata_q;
                        p0_rsp_err   = rsp_err_q;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            if (accept) begin
                last_grant_q <= acc1;
                owner_q      <= acc1;
                we_q         <= sel_we;
                err_q        <= sel_err;
                idx_q        <= sel_addr[AW+1:2];
                wdata_q      <= sel_wdata;
            end
            if (state_q == ACCESS) begin
                rsp_rdata_q <= (~we_q & ~err_q) ? mem_rdata : '0;
                rsp_err_q   <= err_q;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table vectors plus scoreboard monitor for dmem_arbiter.
// Drives at posedge+1, samples on negedge; models the 32-word memory.
module tb_dmem_arbiter;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        p0_valid = 1'b0, p0_we = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0;
    logic        p1_valid = 1'b0, p1_we = 1'b0;
    logic [31:0] p1_addr = '0, p1_wdata = '0;
    logic        p0_ready, p1_ready;
    logic        p0_rsp_valid, p1_rsp_valid;
    logic [31:0] p0_rsp_rdata, p1_rsp_rdata;
    logic        p0_rsp_err, p1_rsp_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wen, busy;

    dmem_arbiter dut (
        .Clk(Clk), .Rst(Rst),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
        .p0_rsp_err(p0_rsp_err),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
        .p1_rsp_err(p1_rsp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 Clk = ~Clk;

    // Physical memory seen by the DUT.
    logic [31:0] phys [32];
    bit          phys_init = 1'b0;
    assign mem_rdata = phys[mem_addr[4:0]];

    always @(posedge Clk) begin
        if (!phys_init) begin
            for (int i = 0; i < 32; i++) phys[i] <= 32'hA500_0000 | i;
            phys_init <= 1'b1;
        end else if (mem_wen) begin
            phys[mem_addr[4:0]] <= mem_wdata;
        end
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic bad(input string nm);
        total_cnt++;
        $display("FAIL %s: event seen, none allowed", nm);
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [4:0]  idx;
        bit          err;
        logic [31:0] wdata;
        int          cyc;
    } sb_t;

    sb_t         sbq[$];
    int          grants[$];
    int          acc1_cyc[$];
    int          cyc = 0;
    logic [31:0] model [32];
    bit          model_init = 1'b0;

    always @(negedge Clk) begin
        sb_t         e;
        logic [31:0] a, rd, oth;
        bit          er, ew;
        cyc++;
        if (!model_init) begin
            for (int i = 0; i < 32; i++) model[i] = 32'hA500_0000 | i;
            model_init = 1'b1;
        end
        if (Rst) begin
            chk("rst_ready", {31'b0, p0_ready | p1_ready}, 32'd0);
            chk("rst_wen", {31'b0, mem_wen}, 32'd0);
            sbq.delete();
        end else begin
            if (p0_rsp_valid || p1_rsp_valid) begin
                if (sbq.size() == 0) begin
                    bad("rsp_unexpected");
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_both", {31'b0, p0_rsp_valid & p1_rsp_valid}, 0);
                    chk("rsp_port", {31'b0, p1_rsp_valid}, {31'b0, e.port});
                    chk("rsp_lat", cyc - e.cyc, 2);
                    rd  = e.port ? p1_rsp_rdata : p0_rsp_rdata;
                    er  = e.port ? p1_rsp_err : p0_rsp_err;
                    oth = e.port ? (p0_rsp_rdata | {31'b0, p0_rsp_err})
                                 : (p1_rsp_rdata | {31'b0, p1_rsp_err});
                    chk("rsp_rdata", rd,
                        (e.we || e.err) ? 32'd0 : model[e.idx]);
                    chk("rsp_err", {31'b0, er}, {31'b0, e.err});
                    chk("rsp_other_zero", oth, 0);
                    if (e.we && !e.err) model[e.idx] = e.wdata;
                end
            end
            if (sbq.size() > 0 && sbq[0].cyc == cyc - 1) begin
                ew = sbq[0].we & ~sbq[0].err;
                chk("busy", {31'b0, busy}, 1);
                chk("wen", {31'b0, mem_wen}, {31'b0, ew});
                if (ew) begin
                    chk("waddr", mem_addr, {27'b0, sbq[0].idx});
                    chk("wdata", mem_wdata, sbq[0].wdata);
                end
            end else if (mem_wen || busy) begin
                bad("spurious_wen_busy");
            end
            if (p0_ready && p1_ready) bad("both_ready");
            if ((p0_ready && !p0_valid) || (p1_ready && !p1_valid))
                bad("ready_no_valid");
            if ((p0_valid && p0_ready) || (p1_valid && p1_ready)) begin
                e.port  = p1_valid && p1_ready;
                a       = e.port ? p1_addr : p0_addr;
                e.we    = e.port ? p1_we : p0_we;
                e.wdata = e.port ? p1_wdata : p0_wdata;
                e.idx   = a[6:2];
                e.err   = (a[1:0] != 2'b00) || (a[31:7] != 25'd0);
                e.cyc   = cyc;
                sbq.push_back(e);
                grants.push_back(int'(e.port));
                if (e.port) acc1_cyc.push_back(cyc);
            end
        end
    end

    task automatic drive(input bit p, input bit v, input bit we,
                         input logic [31:0] a, input logic [31:0] wd);
        if (p) begin
            p1_valid = v; p1_we = we; p1_addr = a; p1_wdata = wd;
        end else begin
            p0_valid = v; p0_we = we; p0_addr = a; p0_wdata = wd;
        end
    endtask

    task automatic req(input bit p, input bit we,
                       input logic [31:0] a, input logic [31:0] wd);
        int n = 0;
        @(posedge Clk); #1;
        drive(p, 1'b1, we, a, wd);
        do begin
            @(negedge Clk);
            n++;
        end while (!(p ? p1_ready : p0_ready) && n < 20);
        if (!(p ? p1_ready : p0_ready)) bad("req_timeout");
        @(posedge Clk); #1;
        drive(p, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic wait_rsp(input bit p, output logic [31:0] rd,
                            output bit er);
        int n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!(p ? p1_rsp_valid : p0_rsp_valid) && n < 10);
        if (!(p ? p1_rsp_valid : p0_rsp_valid)) bad("rsp_timeout");
        rd = p ? p1_rsp_rdata : p0_rsp_rdata;
        er = p ? p1_rsp_err : p0_rsp_err;
    endtask

    task automatic do_reset();
        @(posedge Clk); #1;
        Rst = 1'b1;
        p0_valid = 1'b1;
        p1_valid = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        @(negedge Clk);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_mem_wen", {31'b0, mem_wen}, 0);
        chk("rst_rsp_valid", {30'b0, p1_rsp_valid, p0_rsp_valid}, 0);
        chk("rst_rsp_err", {30'b0, p1_rsp_err, p0_rsp_err}, 0);
        chk("rst_rdata", p0_rsp_rdata | p1_rsp_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        bit          er;
        int          n;
        int          start;

        vecs[0]  = '{1'b1, 1'b1, 32'h0000_0081, 32'h1111_1111, 1'b1, 32'h0};
        vecs[1]  = '{1'b1, 1'b1, 32'h0000_0080, 32'h2222_2222, 1'b1, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0080, 32'h0, 1'b1, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0000_0014, 32'h0, 1'b0, 32'hA500_0005};
        vecs[4]  = '{1'b1, 1'b1, 32'h0000_007C, 32'h1234_5678, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 1'b0, 32'h0000_007C, 32'h0, 1'b0, 32'h1234_5678};
        vecs[6]  = '{1'b0, 1'b0, 32'h0000_0002, 32'h0, 1'b1, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 32'h1000_0000, 32'h0, 1'b1, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b0, 32'hA500_0000};
        vecs[9]  = '{1'b0, 1'b1, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b0, 32'hCAFE_F00D};

        do_reset();

        // Store then load issued during the store's RESP cycle.
        @(posedge Clk); #1;
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        @(negedge Clk);
        chk("st_ready", {31'b0, p0_ready}, 1);
        @(posedge Clk); #1;
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        @(negedge Clk);
        chk("st_wen", {31'b0, mem_wen}, 1);
        chk("st_addr", mem_addr, 32'd4);
        chk("st_ready_access", {31'b0, p0_ready}, 0);
        @(negedge Clk);
        chk("st_rsp_valid", {31'b0, p0_rsp_valid}, 1);
        chk("st_rsp_err", {31'b0, p0_rsp_err}, 0);
        chk("st_rsp_rdata", p0_rsp_rdata, 0);
        chk("ld_ready_in_resp", {31'b0, p0_ready}, 1);
        @(posedge Clk); #1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge Clk);
        chk("ld_wen", {31'b0, mem_wen}, 0);
        @(negedge Clk);
        chk("ld_rsp_valid", {31'b0, p0_rsp_valid}, 1);
        chk("ld_raw_rdata", p0_rsp_rdata, 32'hDEAD_BEEF);

        for (int i = 0; i < 11; i++) begin
            req(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            wait_rsp(vecs[i].port, rd, er);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), {31'b0, er},
                {31'b0, vecs[i].exp_err});
        end

        // Reset during the ACCESS cycle of a store to 0x8.
        @(posedge Clk); #1;
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0008, 32'h7777_7777);
        @(negedge Clk);
        chk("abort_ready", {31'b0, p0_ready}, 1);
        @(posedge Clk); #1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        Rst = 1'b1;
        @(negedge Clk);
        chk("abort_wen", {31'b0, mem_wen}, 0);
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(negedge Clk);
        chk("abort_idle", {31'b0, busy}, 0);
        chk("abort_no_rsp", {31'b0, p0_rsp_valid}, 0);
        @(negedge Clk);
        chk("abort_no_rsp2", {31'b0, p0_rsp_valid}, 0);
        chk("abort_mem", phys[2], 32'hA500_0002);
        req(1'b0, 1'b0, 32'h0000_0008, 32'h0);
        wait_rsp(1'b0, rd, er);
        chk("abort_old_data", rd, 32'hA500_0002);

        // Both ports continuously valid.
        do_reset();
        @(posedge Clk); #1;
        grants.delete();
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0014, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0018, 32'h0);
        n = 0;
        do begin
            @(negedge Clk); #1;
            n++;
        end while (grants.size() < 8 && n < 60);
        @(posedge Clk); #1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (4) @(negedge Clk);
        chk("rr_count", grants.size(), 8);
        for (int i = 0; i < 8 && i < grants.size(); i++)
            chk($sformatf("rr_grant%0d", i), grants[i], i % 2);

        // Port 1 alone, held valid.
        @(posedge Clk); #1;
        acc1_cyc.delete();
        start = cyc;
        drive(1'b1, 1'b1, 1'b0, 32'h0000_007C, 32'h0);
        n = 0;
        do begin
            @(negedge Clk); #1;
            n++;
        end while (acc1_cyc.size() < 5 && n < 40);
        @(posedge Clk); #1;
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (4) @(negedge Clk);
        chk("p1_count", acc1_cyc.size(), 5);
        if (acc1_cyc.size() > 0)
            chk("p1_first", acc1_cyc[0] - start, 1);
        for (int i = 1; i < acc1_cyc.size(); i++)
            chk($sformatf("p1_gap%0d", i), acc1_cyc[i] - acc1_cyc[i-1], 2);

        #1;
        chk("sb_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
